ahci_slot_fsm: RTL and testbench

AHCI_SLOT_FSM -- requirements
Module: ahci_slot_fsm

---
 rtl/ahci_slot_fsm.sv | 183 ++++++++++++++++++
 tb/tb_ahci_slot_fsm.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ahci_slot_fsm.sv
// AHCI command-slot issue FSM: tracks pending PxCI slots, issues one at a time, writes PxCI back.
// Define AHCI_SLOT_RR_EN for round-robin slot selection; default picks the lowest pending slot.
module ahci_slot_fsm #(
    parameter int unsigned NUM_SLOTS = 32,
    parameter int unsigned ADDRESS_BITS = 10,
    parameter logic [ADDRESS_BITS-1:0] PXCI_ADDR = 'h4e
) (
    input  logic                    mclk,
    input  logic                    hba_rst_n,
    input  logic [ADDRESS_BITS-1:0] soft_write_addr,
    input  logic [31:0]             soft_write_data,
    input  logic                    soft_write_en,
    input  logic                    st,
    input  logic                    phy_ready,
    input  logic                    done,
    input  logic                    cmd_err,
    output logic                    fetch_cmd,
    output logic [4:0]              cmd_slot,
    output logic                    cmd_abort,
    output logic                    slot_done,
    output logic                    err_halt,
    output logic [NUM_SLOTS-1:0]    ci,
    output logic [ADDRESS_BITS-1:0] regs_addr,
    output logic                    regs_we,
    output logic [31:0]             regs_din
);

    typedef enum logic [1:0] {StIdle, StBusy, StWb, StErr} state_e;

    state_e                  state_q, state_d;
    logic [NUM_SLOTS-1:0]    ci_q, ci_d;
    logic [4:0]              cmd_slot_q, cmd_slot_d;
    logic                    fetch_q, fetch_d;
    logic                    abort_q, abort_d;
    logic                    slot_done_q, slot_done_d;
    logic                    err_halt_q, err_halt_d;
    logic                    regs_we_q, regs_we_d;
    logic [ADDRESS_BITS-1:0] regs_addr_q, regs_addr_d;
    logic [31:0]             regs_din_q, regs_din_d;

    logic [NUM_SLOTS-1:0]    set_mask, clr_mask;
    logic [4:0]              sel_slot;

    always_comb begin
        set_mask = '0;
        if (soft_write_en && st && soft_write_addr == PXCI_ADDR) begin
            set_mask = soft_write_data[NUM_SLOTS-1:0];
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
            clr_mask[i] = (cmd_slot_q == 5'(i));
        end
    end

`ifdef AHCI_SLOT_RR_EN
    logic [4:0] rr_q, rr_d;

    // Pick the pending slot with the smallest forward distance from the pointer.
    always_comb begin
        int best;
        int dist;
        best     = NUM_SLOTS + 1;
        dist     = 0;
        sel_slot = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            dist = (i > int'(rr_q)) ? i - int'(rr_q) : i + NUM_SLOTS - int'(rr_q);
            if (ci_q[i] && dist < best) begin
                best     = dist;
                sel_slot = 5'(i);
            end
        end
    end
`else
    always_comb begin
        sel_slot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (ci_q[i]) sel_slot = 5'(i);
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        ci_d        = ci_q | set_mask;
        cmd_slot_d  = cmd_slot_q;
        fetch_d     = 1'b0;
        abort_d     = 1'b0;
        slot_done_d = 1'b0;
        err_halt_d  = err_halt_q;
        regs_we_d   = 1'b0;
        regs_addr_d = regs_addr_q;
        regs_din_d  = regs_din_q;
`ifdef AHCI_SLOT_RR_EN
        rr_d        = rr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (st && phy_ready && (|ci_q)) begin
                    cmd_slot_d = sel_slot;
                    fetch_d    = 1'b1;
                    state_d    = StBusy;
`ifdef AHCI_SLOT_RR_EN
                    rr_d       = sel_slot;
`endif
                end
            end
            StBusy: begin
                // Stop wins over a completion arriving on the same edge.
                if (!st) begin
                    ci_d       = '0;
                    abort_d    = 1'b1;
                    err_halt_d = 1'b0;
                    state_d    = StWb;
                end else if (done && !cmd_err) begin
                    ci_d        = (ci_q & ~clr_mask) | set_mask;
                    slot_done_d = 1'b1;
                    state_d     = StWb;
                end else if (done || !phy_ready) begin
                    err_halt_d = 1'b1;
                    state_d    = StErr;
                end
            end
            StErr: begin
                if (!st) begin
                    ci_d       = '0;
                    err_halt_d = 1'b0;
                    state_d    = StWb;
                end
            end
            StWb: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (state_d == StWb) begin
            regs_we_d   = 1'b1;
            regs_addr_d = PXCI_ADDR;
            regs_din_d  = 32'(ci_d);
        end
    end

    always_ff @(posedge mclk or negedge hba_rst_n) begin
        if (!hba_rst_n) begin
            state_q     <= StIdle;
            ci_q        <= '0;
            cmd_slot_q  <= '0;
            fetch_q     <= 1'b0;
            abort_q     <= 1'b0;
            slot_done_q <= 1'b0;
            err_halt_q  <= 1'b0;
            regs_we_q   <= 1'b0;
            regs_addr_q <= '0;
            regs_din_q  <= '0;
`ifdef AHCI_SLOT_RR_EN
            rr_q        <= 5'(NUM_SLOTS - 1);
`endif
        end else begin
            state_q     <= state_d;
            ci_q        <= ci_d;
            cmd_slot_q  <= cmd_slot_d;
            fetch_q     <= fetch_d;
            abort_q     <= abort_d;
            slot_done_q <= slot_done_d;
            err_halt_q  <= err_halt_d;
            regs_we_q   <= regs_we_d;
            regs_addr_q <= regs_addr_d;
            regs_din_q  <= regs_din_d;
`ifdef AHCI_SLOT_RR_EN
            rr_q        <= rr_d;
`endif
        end
    end

    assign fetch_cmd = fetch_q;
    assign cmd_slot  = cmd_slot_q;
    assign cmd_abort = abort_q;
    assign slot_done = slot_done_q;
    assign err_halt  = err_halt_q;
    assign ci        = ci_q;
    assign regs_we   = regs_we_q;
    assign regs_addr = regs_addr_q;
    assign regs_din  = regs_din_q;

endmodule

// File: tb/tb_ahci_slot_fsm.sv
// Directed vector bench for ahci_slot_fsm with 8 slots; honours AHCI_SLOT_RR_EN when defined.
module tb_ahci_slot_fsm;

    localparam int unsigned NS = 8;
    localparam int unsigned AB = 10;
    localparam logic [AB-1:0] PXCI = 10'h4e;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic          mclk = 1'b0;
    logic          hba_rst_n = 1'b0;
    logic [AB-1:0] soft_write_addr = PXCI;
    logic [31:0]   soft_write_data = '0;
    logic          soft_write_en = 1'b0;
    logic          st = 1'b0;
    logic          phy_ready = 1'b0;
    logic          done = 1'b0;
    logic          cmd_err = 1'b0;
    logic          fetch_cmd, cmd_abort, slot_done, err_halt, regs_we;
    logic [4:0]    cmd_slot;
    logic [NS-1:0] ci;
    logic [AB-1:0] regs_addr;
    logic [31:0]   regs_din;

    int n_checks = 0;
    int n_fail   = 0;

    ahci_slot_fsm #(.NUM_SLOTS(NS), .ADDRESS_BITS(AB), .PXCI_ADDR(PXCI)) dut (
        .mclk(mclk), .hba_rst_n(hba_rst_n),
        .soft_write_addr(soft_write_addr), .soft_write_data(soft_write_data),
        .soft_write_en(soft_write_en), .st(st), .phy_ready(phy_ready),
        .done(done), .cmd_err(cmd_err), .fetch_cmd(fetch_cmd), .cmd_slot(cmd_slot),
        .cmd_abort(cmd_abort), .slot_done(slot_done), .err_halt(err_halt), .ci(ci),
        .regs_addr(regs_addr), .regs_we(regs_we), .regs_din(regs_din)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        logic wr; logic [31:0] wd; logic st; logic phy; logic done; logic err;
        logic f; logic [4:0] s; logic a; logic sd; logic eh; logic [7:0] ci;
        logic we; logic [31:0] din;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mkv(logic wr, logic [31:0] wd, logic s_in, logic p, logic d,
                                 logic e, logic f, logic [4:0] s, logic a, logic sd,
                                 logic eh, logic [7:0] c, logic we, logic [31:0] din);
        vec_t v;
        v.wr = wr; v.wd = wd; v.st = s_in; v.phy = p; v.done = d; v.err = e;
        v.f = f; v.s = s; v.a = a; v.sd = sd; v.eh = eh; v.ci = c; v.we = we; v.din = din;
        return v;
    endfunction

    function automatic logic [49:0] pk(logic f, logic [4:0] s, logic a, logic sd, logic eh,
                                       logic [7:0] c, logic we, logic [31:0] din);
        return {f, s, a, sd, eh, c, we, din};
    endfunction

    task automatic chk(input string name, input logic [49:0] got, input logic [49:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic cyc(input logic wr, input logic [31:0] wd, input logic s_in, input logic p,
                       input logic d, input logic e);
        @(negedge mclk);
        soft_write_en = wr; soft_write_data = wd; st = s_in; phy_ready = p;
        done = d; cmd_err = e;
        @(posedge mclk);
        #1;
    endtask

    task automatic idle();
        cyc(L, 32'h0, H, H, L, L);
    endtask

    // Issue the next slot (expected exp_slot), complete it successfully, return to idle.
    task automatic issue_done(input logic [4:0] exp_slot, input string name);
        idle();
        chk({name, "_fetch"}, 50'(fetch_cmd), 50'(1));
        chk({name, "_slot"}, 50'(cmd_slot), 50'(exp_slot));
        cyc(L, 32'h0, H, H, H, L);
        chk({name, "_sdone"}, 50'(slot_done), 50'(1));
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //               wr  wd     st phy dn err  f  s     a  sd eh ci     we din
        vecs[0]  = mkv(H, 32'h5, H, H, L, L,  L, 5'd0, L, L, L, 8'h05, L, 32'h0);
        vecs[1]  = mkv(L, 32'h0, H, H, L, L,  H, 5'd0, L, L, L, 8'h05, L, 32'h0);
        vecs[2]  = mkv(L, 32'h0, H, H, L, L,  L, 5'd0, L, L, L, 8'h05, L, 32'h0);
        vecs[3]  = mkv(L, 32'h0, H, H, H, L,  L, 5'd0, L, H, L, 8'h04, H, 32'h4);
        vecs[4]  = mkv(L, 32'h0, H, H, L, L,  L, 5'd0, L, L, L, 8'h04, L, 32'h4);
        vecs[5]  = mkv(L, 32'h0, H, H, L, L,  H, 5'd2, L, L, L, 8'h04, L, 32'h4);
        vecs[6]  = mkv(L, 32'h0, H, H, H, L,  L, 5'd2, L, H, L, 8'h00, H, 32'h0);
        vecs[7]  = mkv(L, 32'h0, H, H, L, L,  L, 5'd2, L, L, L, 8'h00, L, 32'h0);
        vecs[8]  = mkv(H, 32'h8, H, H, L, L,  L, 5'd2, L, L, L, 8'h08, L, 32'h0);
        vecs[9]  = mkv(L, 32'h0, H, H, L, L,  H, 5'd3, L, L, L, 8'h08, L, 32'h0);
        vecs[10] = mkv(L, 32'h0, H, H, H, H,  L, 5'd3, L, L, H, 8'h08, L, 32'h0);
        vecs[11] = mkv(L, 32'h0, H, H, L, L,  L, 5'd3, L, L, H, 8'h08, L, 32'h0);
        vecs[12] = mkv(L, 32'h0, L, H, L, L,  L, 5'd3, L, L, L, 8'h00, H, 32'h0);
        vecs[13] = mkv(L, 32'h0, H, H, L, L,  L, 5'd3, L, L, L, 8'h00, L, 32'h0);
        vecs[14] = mkv(H, 32'h1, L, H, L, L,  L, 5'd3, L, L, L, 8'h00, L, 32'h0);
        vecs[15] = mkv(H, 32'h1, H, L, L, L,  L, 5'd3, L, L, L, 8'h01, L, 32'h0);
        vecs[16] = mkv(L, 32'h0, H, L, L, L,  L, 5'd3, L, L, L, 8'h01, L, 32'h0);
        vecs[17] = mkv(L, 32'h0, H, H, L, L,  H, 5'd0, L, L, L, 8'h01, L, 32'h0);
        vecs[18] = mkv(L, 32'h0, H, L, L, L,  L, 5'd0, L, L, H, 8'h01, L, 32'h0);
        vecs[19] = mkv(L, 32'h0, L, L, L, L,  L, 5'd0, L, L, L, 8'h00, H, 32'h0);
        vecs[20] = mkv(L, 32'h0, H, H, L, L,  L, 5'd0, L, L, L, 8'h00, L, 32'h0);

        #12;
        chk("reset_outputs", pk(fetch_cmd, cmd_slot, cmd_abort, slot_done, err_halt, ci,
                                regs_we, regs_din), 50'(0));
        chk("reset_addr", 50'(regs_addr), 50'(0));
        @(negedge mclk);
        hba_rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            cyc(vecs[i].wr, vecs[i].wd, vecs[i].st, vecs[i].phy, vecs[i].done, vecs[i].err);
            chk($sformatf("vec%0d", i),
                pk(fetch_cmd, cmd_slot, cmd_abort, slot_done, err_halt, ci, regs_we, regs_din),
                pk(vecs[i].f, vecs[i].s, vecs[i].a, vecs[i].sd, vecs[i].eh, vecs[i].ci,
                   vecs[i].we, vecs[i].din));
            if (vecs[i].we) chk($sformatf("vec%0d_addr", i), 50'(regs_addr), 50'(PXCI));
        end

        // Stop during BUSY on slot 7 with a simultaneous successful done.
        cyc(H, 32'h80, H, H, L, L);
        idle();
        chk("abort_fetch_slot", 50'(cmd_slot), 50'(7));
        cyc(L, 32'h0, L, H, H, L);
        chk("abort_pulse", pk(L, 5'd0, cmd_abort, slot_done, err_halt, ci, regs_we, regs_din),
            pk(L, 5'd0, H, L, L, 8'h00, H, 32'h0));
        idle();
        chk("abort_one_cycle", 50'({cmd_abort, regs_we}), 50'(0));

        // Re-issue of slot 1 on the same edge as its successful completion.
        cyc(H, 32'h2, H, H, L, L);
        idle();
        chk("reissue_first_slot", 50'(cmd_slot), 50'(1));
        cyc(H, 32'h2, H, H, H, L);
        chk("reissue_wb", pk(L, 5'd0, L, slot_done, L, ci, regs_we, regs_din),
            pk(L, 5'd0, L, H, L, 8'h02, H, 32'h2));
        idle();
        chk("reissue_ci_after_wb", 50'(ci), 50'(2));
        issue_done(5'd1, "reissue_again");

        // Slot 2 then a burst of 0x7: 0,1,2 in either selection mode.
        cyc(H, 32'h4, H, H, L, L);
        issue_done(5'd2, "burst_pre");
        cyc(H, 32'h7, H, H, L, L);
        issue_done(5'd0, "burst0");
        issue_done(5'd1, "burst1");
        issue_done(5'd2, "burst2");

        // 0x6, then 0x1 while busy on slot 1.
        cyc(H, 32'h6, H, H, L, L);
        idle();
        chk("late_first", 50'({fetch_cmd, cmd_slot}), 50'({1'b1, 5'd1}));
        cyc(H, 32'h1, H, H, L, L);
        chk("late_ci_set", 50'(ci), 50'(7));
        cyc(L, 32'h0, H, H, H, L);
        chk("late_ci_clr", 50'(ci), 50'(5));
        idle();
        idle();
`ifdef AHCI_SLOT_RR_EN
        chk("late_next", 50'({fetch_cmd, cmd_slot}), 50'({1'b1, 5'd2}));
`else
        chk("late_next", 50'({fetch_cmd, cmd_slot}), 50'({1'b1, 5'd0}));
`endif
        cyc(L, 32'h0, L, H, L, L);
        chk("late_abort", 50'({cmd_abort, ci}), 50'({1'b1, 8'h00}));
        idle();

        // Asynchronous reset while busy with outputs active.
        cyc(H, 32'h10, H, H, L, L);
        idle();
        chk("pre_reset_fetch", 50'({fetch_cmd, cmd_slot}), 50'({1'b1, 5'd4}));
        hba_rst_n = 1'b0;
        #1;
        chk("async_reset", pk(fetch_cmd, cmd_slot, cmd_abort, slot_done, err_halt, ci,
                              regs_we, regs_din), 50'(0));
        @(negedge mclk);
        hba_rst_n = 1'b1;
        idle();
        chk("post_reset_idle", 50'({fetch_cmd, ci}), 50'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
